// File: rtl/arb_mux_pkg.sv
// Shared definitions for the arb_mux packet multiplexer: FSM state encoding
// and the mux_MODE constants.
package arb_mux_pkg;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } state_t;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin winner search.
// Ports:
//   req         - per-channel request vector
//   ptr         - last granted channel; search starts at ptr+1 and wraps
//   grant       - index of the first requesting channel found
//   grant_valid - at least one channel is requesting
module rr_arbiter #(
   parameter  int unsigned SEL_WIDTH = 2,
   localparam int unsigned NUM_CH    = 2**SEL_WIDTH
) (
   input  logic [NUM_CH-1:0]    req,
   input  logic [SEL_WIDTH-1:0] ptr,
   output logic [SEL_WIDTH-1:0] grant,
   output logic                 grant_valid
);

   logic [SEL_WIDTH-1:0] idx;

   // Index arithmetic is SEL_WIDTH bits wide, so wrap-around is free.
   always_comb begin
      grant       = '0;
      grant_valid = 1'b0;
      idx         = '0;
      for (int unsigned i = 1; i <= NUM_CH; i++) begin
         idx = ptr + SEL_WIDTH'(i);
         if (!grant_valid && req[idx]) begin
            grant       = idx;
            grant_valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/arb_mux.sv
// Packet-aware N:1 multiplexer with fixed-select or round-robin arbitration.
// A channel that starts a multi-beat packet owns the output until its last
// beat, so packets are never interleaved. Output beat is registered.
// Ports:
//   CLK, RST             - clock, async active-low reset
//   mux_MODE, mux_SEL    - 0: fixed select of mux_SEL, 1: round-robin
//   in_VALID/LAST/DATA   - per-channel input beats (channel i at bits i*DATA_WIDTH)
//   in_READY             - per-channel accept, at most one bit high
//   out_VALID/LAST/DATA  - registered output beat
//   out_CH               - source channel of the current output beat
//   out_READY            - downstream accept
module arb_mux
   import arb_mux_pkg::*;
#(
   parameter  int unsigned SEL_WIDTH  = 2,
   parameter  int unsigned DATA_WIDTH = 8,
   localparam int unsigned NUM_CH     = 2**SEL_WIDTH
) (
   input  logic                         CLK,
   input  logic                         RST,
   input  logic                         mux_MODE,
   input  logic [SEL_WIDTH-1:0]         mux_SEL,
   input  logic [NUM_CH-1:0]            in_VALID,
   input  logic [NUM_CH-1:0]            in_LAST,
   input  logic [NUM_CH*DATA_WIDTH-1:0] in_DATA,
   output logic [NUM_CH-1:0]            in_READY,
   output logic                         out_VALID,
   input  logic                         out_READY,
   output logic [DATA_WIDTH-1:0]        out_DATA,
   output logic                         out_LAST,
   output logic [SEL_WIDTH-1:0]         out_CH
);

   state_t               state;
   logic [SEL_WIDTH-1:0] lock_ch;
   logic [SEL_WIDTH-1:0] rr_ptr;

   logic                  load;
   logic [SEL_WIDTH-1:0]  arb_ch;
   logic                  arb_valid;
   logic [SEL_WIDTH-1:0]  sel_ch;
   logic                  sel_grant;
   logic [DATA_WIDTH-1:0] sel_data;
   logic                  sel_last;
   logic                  xfer;

   // Output register can take a new beat when empty or being drained.
   assign load = !out_VALID || out_READY;

   rr_arbiter #(
      .SEL_WIDTH (SEL_WIDTH)
   ) u_rr_arbiter (
      .req         (in_VALID),
      .ptr         (rr_ptr),
      .grant       (arb_ch),
      .grant_valid (arb_valid)
   );

   // Channel choice: owner while LOCKED (granted even if it is idling),
   // otherwise the arbiter or mux_SEL depending on mode.
   always_comb begin
      sel_ch    = lock_ch;
      sel_grant = 1'b1;
      if (state == ST_IDLE) begin
         if (mux_MODE == MODE_RR) begin
            sel_ch    = arb_ch;
            sel_grant = arb_valid;
         end else begin
            sel_ch    = mux_SEL;
            sel_grant = in_VALID[mux_SEL];
         end
      end
   end

   // Payload mux and one-hot ready; ready is forced low while in reset.
   always_comb begin
      sel_data = '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         if (sel_ch == SEL_WIDTH'(i)) begin
            sel_data = in_DATA[i*DATA_WIDTH +: DATA_WIDTH];
         end
      end
      sel_last = in_LAST[sel_ch];
      in_READY = '0;
      if (RST && load && sel_grant) begin
         in_READY[sel_ch] = 1'b1;
      end
      xfer = |(in_READY & in_VALID);
   end

   // Output register, lock FSM and round-robin pointer.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         out_VALID <= 1'b0;
         out_DATA  <= '0;
         out_LAST  <= 1'b0;
         out_CH    <= '0;
         state     <= ST_IDLE;
         lock_ch   <= '0;
         rr_ptr    <= SEL_WIDTH'(NUM_CH - 1);
      end else begin
         if (xfer) begin
            out_VALID <= 1'b1;
            out_DATA  <= sel_data;
            out_LAST  <= sel_last;
            out_CH    <= sel_ch;
         end else if (out_READY) begin
            out_VALID <= 1'b0;
         end

         if (xfer) begin
            if (state == ST_IDLE) begin
               rr_ptr <= sel_ch;
               if (!sel_last) begin
                  state   <= ST_LOCKED;
                  lock_ch <= sel_ch;
               end
            end else if (sel_last) begin
               state <= ST_IDLE;
            end
         end
      end
   end

endmodule

// File: tb/tb_arb_mux.sv
module tb_arb_mux;

   localparam int N  = 4;
   localparam int DW = 8;

   logic          CLK;
   logic          RST;
   logic          mux_MODE;
   logic [1:0]    mux_SEL;
   logic [N-1:0]  in_VALID;
   logic [N-1:0]  in_LAST;
   logic [N*DW-1:0] in_DATA;
   logic [N-1:0]  in_READY;
   logic          out_VALID;
   logic          out_READY;
   logic [DW-1:0] out_DATA;
   logic          out_LAST;
   logic [1:0]    out_CH;

   int vectors;
   int miscompares;

   arb_mux #(.SEL_WIDTH(2), .DATA_WIDTH(DW)) dut (
      .CLK       (CLK),
      .RST       (RST),
      .mux_MODE  (mux_MODE),
      .mux_SEL   (mux_SEL),
      .in_VALID  (in_VALID),
      .in_LAST   (in_LAST),
      .in_DATA   (in_DATA),
      .in_READY  (in_READY),
      .out_VALID (out_VALID),
      .out_READY (out_READY),
      .out_DATA  (out_DATA),
      .out_LAST  (out_LAST),
      .out_CH    (out_CH)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic chk(input string name, input int act, input int exp);
      vectors++;
      if (act != exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural reference model ----------------
   int m_owner;     // channel owning the output, -1 when free
   int m_ptr;       // last channel granted from idle
   int m_ov;
   int m_data;
   int m_last;
   int m_ch;
   int open_ch;     // output-side packet in progress, -1 when none

   function automatic void m_reset();
      m_owner = -1;
      m_ptr   = N - 1;
      m_ov    = 0;
      m_data  = 0;
      m_last  = 0;
      m_ch    = 0;
      open_ch = -1;
   endfunction

   always @(negedge CLK) begin : model_check
      int c;
      int exp_rdy;
      int idx;
      bit load;
      if (!RST) m_reset();
      load    = (m_ov == 0) || out_READY;
      c       = -1;
      exp_rdy = 0;
      if (RST && load) begin
         if (m_owner >= 0) c = m_owner;
         else if (mux_MODE) begin
            for (int k = 1; k <= N; k++) begin
               idx = (m_ptr + k) % N;
               if (c < 0 && in_VALID[idx]) c = idx;
            end
         end else if (in_VALID[mux_SEL]) c = int'(mux_SEL);
         if (c >= 0) exp_rdy = 1 << c;
      end
      chk("in_ready", int'(in_READY), exp_rdy);
      chk("out_valid", int'(out_VALID), m_ov);
      if (m_ov != 0 || !RST)
         chk("out_beat{ch,last,data}", int'({out_CH, out_LAST, out_DATA}),
             (m_ch << 9) | (m_last << 8) | m_data);
      if (RST && out_VALID && out_READY) begin
         if (open_ch >= 0) chk("no_interleave", int'(out_CH), open_ch);
         open_ch = out_LAST ? -1 : int'(out_CH);
      end
      if (RST && c >= 0 && in_VALID[c]) begin
         m_ov   = 1;
         m_data = int'(in_DATA[c*DW +: DW]);
         m_last = int'(in_LAST[c]);
         m_ch   = c;
         if (m_owner < 0) begin
            m_ptr = c;
            if (!in_LAST[c]) m_owner = c;
         end else if (in_LAST[c]) m_owner = -1;
      end else if (RST && out_READY) begin
         m_ov = 0;
      end
   end

   // ---------------- directed packet sources ----------------
   int         nbeats[N];
   int         pkl[N];
   int         bidx[N];
   logic [7:0] base[N];
   bit         fixed_switch;
   int         bch[$];
   int         bdat[$];

   task automatic src_clear();
      for (int c = 0; c < N; c++) begin
         nbeats[c] = 0;
         pkl[c]    = 1;
         bidx[c]   = 0;
         base[c]   = 8'h00;
      end
      bch.delete();
      bdat.delete();
   endtask

   task automatic drive_src();
      for (int c = 0; c < N; c++) begin
         in_VALID[c]          = (bidx[c] < nbeats[c]);
         in_LAST[c]           = (((bidx[c] + 1) % pkl[c]) == 0);
         in_DATA[c*DW +: DW]  = base[c] + 8'(bidx[c]);
      end
   endtask

   task automatic do_reset();
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
   endtask

   // Runs the sources with RST released; out_READY low for the given window.
   task automatic run_src(input int cycles, input int stall_from, input int stall_len);
      for (int cyc = 0; cyc < cycles; cyc++) begin
         @(posedge CLK); #1;
         if (fixed_switch && bidx[2] >= 1) mux_SEL = 2'd0;
         drive_src();
         out_READY = !(cyc >= stall_from && cyc < stall_from + stall_len);
         RST = 1'b1;
         @(negedge CLK);
         for (int c = 0; c < N; c++)
            if (in_READY[c] && in_VALID[c]) bidx[c]++;
         if (out_VALID && out_READY) begin
            bch.push_back(int'(out_CH));
            bdat.push_back(int'(out_DATA));
         end
      end
   endtask

   task automatic chk_beats(input string name, input int n, input int ech[8], input int edat[8]);
      for (int i = 0; i < n; i++) begin
         if (i < bch.size()) begin
            chk({name, "_ch"}, bch[i], ech[i]);
            chk({name, "_data"}, bdat[i], edat[i]);
         end else begin
            chk({name, "_missing_beat"}, -1, i);
         end
      end
   endtask

   initial begin
      vectors      = 0;
      miscompares  = 0;
      fixed_switch = 1'b0;
      RST          = 1'b0;
      mux_MODE     = 1'b1;
      mux_SEL      = 2'd0;
      out_READY    = 1'b1;
      in_VALID     = '1;
      in_LAST      = '1;
      in_DATA      = 32'h5A5A_5A5A;
      src_clear();

      // Reset with every channel requesting.
      @(negedge CLK);
      chk("rst_in_ready", int'(in_READY), 0);
      chk("rst_out_valid", int'(out_VALID), 0);
      chk("rst_out_ch", int'(out_CH), 0);
      @(negedge CLK);

      // Round-robin fairness over single-beat packets.
      do_reset();
      src_clear();
      for (int c = 0; c < N; c++) begin
         nbeats[c] = 2;
         base[c]   = 8'(8'h10 * (c + 1));
      end
      run_src(10, 0, 0);
      chk_beats("rr", 5, '{0, 1, 2, 3, 0, 0, 0, 0},
                '{8'h10, 8'h20, 8'h30, 8'h40, 8'h11, 0, 0, 0});
      chk("rr_count", bch.size(), 8);

      // Multi-beat packet locks the output.
      do_reset();
      src_clear();
      nbeats[0] = 1; base[0] = 8'h0C;
      nbeats[1] = 3; pkl[1] = 3; base[1] = 8'hA1;
      nbeats[2] = 1; base[2] = 8'h2C;
      run_src(8, 0, 0);
      chk_beats("lock", 5, '{0, 1, 1, 1, 2, 0, 0, 0},
                '{8'h0C, 8'hA1, 8'hA2, 8'hA3, 8'h2C, 0, 0, 0});

      // Backpressure: three stalled cycles, no loss or duplication.
      do_reset();
      src_clear();
      for (int c = 0; c < N; c++) begin
         nbeats[c] = 1;
         base[c]   = 8'(8'h50 + c);
      end
      run_src(12, 1, 3);
      chk_beats("bp", 4, '{0, 1, 2, 3, 0, 0, 0, 0},
                '{8'h50, 8'h51, 8'h52, 8'h53, 0, 0, 0, 0});
      chk("bp_count", bch.size(), 4);

      // Fixed mode; mux_SEL change while locked is ignored.
      do_reset();
      src_clear();
      mux_MODE = 1'b0;
      mux_SEL  = 2'd2;
      nbeats[0] = 1; base[0] = 8'h0C;
      nbeats[2] = 3; pkl[2] = 3; base[2] = 8'hB1;
      fixed_switch = 1'b1;
      run_src(8, 0, 0);
      fixed_switch = 1'b0;
      chk_beats("fixed", 4, '{2, 2, 2, 0, 0, 0, 0, 0},
                '{8'hB1, 8'hB2, 8'hB3, 8'h0C, 0, 0, 0, 0});
      mux_MODE = 1'b1;

      // Reset in the middle of a ch3 packet.
      do_reset();
      src_clear();
      nbeats[3] = 3; pkl[3] = 3; base[3] = 8'h31;
      run_src(2, 0, 0);
      @(posedge CLK); #1;
      RST = 1'b0;
      @(negedge CLK);
      chk("midrst_out_valid", int'(out_VALID), 0);
      chk("midrst_in_ready", int'(in_READY), 0);
      src_clear();
      for (int c = 0; c < N; c++) begin
         nbeats[c] = 1;
         base[c]   = 8'(8'h60 + c);
      end
      run_src(6, 0, 0);
      chk_beats("midrst", 1, '{0, 0, 0, 0, 0, 0, 0, 0},
                '{8'h60, 0, 0, 0, 0, 0, 0, 0});

      // Randomized traffic, mode changes and occasional resets.
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge CLK); #1;
         RST       = ($urandom_range(0, 299) != 0);
         in_VALID  = 4'($urandom);
         for (int c = 0; c < N; c++) in_LAST[c] = ($urandom_range(0, 2) == 0);
         in_DATA   = $urandom;
         out_READY = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 19) == 0) mux_MODE = ~mux_MODE;
         mux_SEL   = 2'($urandom);
      end
      @(posedge CLK); #1;
      RST = 1'b1;
      @(negedge CLK);
      @(negedge CLK);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/arb_mux.md
ARB_MUX -- requirements
Module: arb_mux

Interface
REQ-001 SHALL have parameter SEL_WIDTH, default 2, channel-select width; NUM_CH = 2**SEL_WIDTH input channels.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, payload width per channel.
REQ-003 SHALL have one clock and an asynchronous, active-low reset: CLK  input  1  clock, all state on rising edge.
REQ-004 RST  input  1  asynchronous active-low reset.
REQ-005 mux_MODE  input  1  0 = fixed select via mux_SEL, 1 = round-robin arbitration.
REQ-006 mux_SEL  input  SEL_WIDTH  channel selected in fixed mode.
REQ-007 in_VALID  input  NUM_CH  per-channel beat valid.
REQ-008 in_LAST  input  NUM_CH  per-channel last beat of packet.
REQ-009 in_DATA  input  NUM_CH*DATA_WIDTH  channel i in bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-010 in_READY  output  NUM_CH  per-channel beat accepted when in_VALID & in_READY.
REQ-011 out_VALID  output  1  registered output beat valid.
REQ-012 out_READY  input  1  downstream accepts beat.
REQ-013 out_DATA  output  DATA_WIDTH  registered payload.
REQ-014 out_LAST  output  1  registered last flag.
REQ-015 out_CH  output  SEL_WIDTH  registered source channel of current beat.

Function
REQ-016 load = !out_VALID | out_READY; output register SHALL capture a beat only when load is 1 and one in_VALID/in_READY transfer occurs.
REQ-017 Latency SHALL be one cycle from input transfer to out_VALID; full throughput of one beat per cycle when out_READY held high.
REQ-018 out_VALID SHALL clear on out_READY when no new transfer occurs in the same cycle; out_DATA/out_LAST/out_CH SHALL hold while out_VALID & !out_READY.
REQ-019 At most one in_READY bit SHALL be high in any cycle; in_READY SHALL be 0 for all channels when load is 0.
REQ-020 FSM states SHALL be IDLE and LOCKED; lock_ch register holds the owning channel in LOCKED.
REQ-021 In IDLE, round-robin mode: winner SHALL be the first valid channel searching upward from rr_ptr+1 with wrap-around from NUM_CH-1 to 0.
REQ-022 In IDLE, fixed mode: winner SHALL be mux_SEL if in_VALID[mux_SEL], else no grant; other valid channels SHALL stall.
REQ-023 mux_MODE and mux_SEL SHALL be sampled only in IDLE; changes while LOCKED SHALL not affect the locked packet.
REQ-024 On IDLE transfer: rr_ptr <= winner; if in_LAST[winner]=0, go LOCKED with lock_ch <= winner; if 1, stay IDLE (single-beat packet).
REQ-025 In LOCKED: in_READY[lock_ch] = load, all others 0; a transfer with in_LAST=1 SHALL return to IDLE; the next arbitration occurs in the following cycle.
REQ-026 A packet SHALL never be interleaved with beats from another channel on the output.
REQ-027 in_VALID deasserting mid-packet in LOCKED SHALL stall the output (no grant to others) until lock_ch resumes.
REQ-028 No valid inputs in IDLE SHALL leave rr_ptr and state unchanged.

Reset
REQ-029 While RST=0: out_VALID=0, out_DATA=0, out_LAST=0, out_CH=0, state=IDLE, lock_ch=0, rr_ptr=NUM_CH-1 (channel 0 highest priority first).
REQ-030 Reset asserted mid-packet SHALL drop the packet and in-flight output beat immediately; no partial state survives.
REQ-031 in_READY SHALL be 0 during reset.

Structure
REQ-032 Package arb_mux_pkg SHALL hold the FSM state encoding (IDLE=0, LOCKED=1) and mode constants (MODE_FIXED=0, MODE_RR=1).
REQ-033 Winner selection SHALL be a combinational sub-module rr_arbiter (inputs request vector, pointer; outputs grant index, grant_valid), parameterised by SEL_WIDTH.
REQ-034 All registers SHALL live in arb_mux; rr_arbiter SHALL be purely combinational.

Verification
REQ-035 Reset: RST=0 with all in_VALID=1 -> out_VALID=0, in_READY=0000, out_CH=0; release -> first grant channel 0.
REQ-036 RR fairness, SEL_WIDTH=2: all channels valid single-beat (LAST=1), out_READY=1 -> out_CH sequence 0,1,2,3,0 on consecutive cycles.
REQ-037 Lock: ch1 sends 3-beat packet (0xA1,0xA2,0xA3, LAST on third) while ch0,ch2 valid -> out_DATA A1,A2,A3 all out_CH=1, then ch2 granted.
REQ-038 Backpressure: out_READY=0 for 3 cycles with out_VALID=1 -> out_DATA held, in_READY=0000; out_READY=1 -> next beat follows next cycle, no loss or duplicate.
REQ-039 Fixed mode: mux_MODE=0, mux_SEL=2, ch0 and ch2 valid -> only ch2 granted; mux_SEL change to 0 mid-packet -> ignored until ch2 LAST.
REQ-040 Reset mid-packet: RST=0 during beat 2 of ch3 packet -> out_VALID=0 next sample, state IDLE, rr_ptr=3 so ch0 wins after release.
